// File: rtl/poly_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : poly_disp_pkg
//  Description : Shared constants and types for the polyphonic display
//                sequencer (slot layout, state encoding, slot type).
//  Revision    : 1.0 - initial release
// ============================================================================
package poly_disp_pkg;

    // Slot layout for one voice inside the display vector
    localparam int SLOT_W            = 16;
    localparam int NOTE_ON_BIT       = 9;
    localparam int UNDER_BIT         = 10;
    localparam int DEFAULT_NOTE_BASE = 36;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        REQ     = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    typedef logic [SLOT_W-1:0] slot_t;

endpackage
`default_nettype wire

// File: rtl/poly_slot_enc.sv
`default_nettype none
// ============================================================================
//  Module      : poly_slot_enc
//  Description : Encodes one voice (note-on flag, 7-bit MIDI note) into a
//                16-bit display slot. Notes below the base set an under-range
//                flag instead of wrapping, so nothing leaks out of the slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_slot_enc
    import poly_disp_pkg::*;
#(
    parameter int NOTE_BASE = DEFAULT_NOTE_BASE
) (
    input  logic              note_on_i,
    input  logic [6:0]        note_i,
    output logic [SLOT_W-1:0] slot_o
);

    localparam logic [6:0] C_BASE7 = 7'(NOTE_BASE);

    // Build the slot from scratch each time so unused bits are always zero
    always_comb begin
        slot_o              = '0;
        slot_o[NOTE_ON_BIT] = note_on_i;
        if (note_i >= C_BASE7) begin
            slot_o[6:0] = note_i - C_BASE7;
        end else begin
            slot_o[UNDER_BIT] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/poly_disp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : poly_disp_seq
//  Description : Frame-rate sequencer. On a frame request it clears an
//                accumulator, polls every voice pair over a req/ack port,
//                encodes both voices into slots, then publishes the whole
//                vector at once with a one-cycle valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_disp_seq
    import poly_disp_pkg::*;
#(
    parameter int NUM_PAIRS = 8,
    parameter int NOTE_BASE = DEFAULT_NOTE_BASE,
    parameter int TIMEOUT   = 255
) (
    input  logic                            clk_sys,
    input  logic                            reset_n,
    input  logic                            frame_start,
    output logic                            rd_req,
    output logic [2:0]                      rd_idx,
    input  logic                            rd_ack,
    input  logic                            sq1_no,
    input  logic                            sq2_no,
    input  logic [6:0]                      sq1_n,
    input  logic [6:0]                      sq2_n,
    output logic [2*NUM_PAIRS*SLOT_W-1:0]   pd_out,
    output logic                            pd_valid,
    output logic                            pd_err,
    output logic                            busy
);

    localparam int             VEC_W    = 2 * NUM_PAIRS * SLOT_W;
    localparam int             PAIR_W   = 2 * SLOT_W;
    localparam int             TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [2:0]     LAST_IDX = 3'(NUM_PAIRS - 1);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               pending_q, pending_d;
    logic               ferr_q, ferr_d;
    logic [VEC_W-1:0]   acc_q, acc_d;
    logic [VEC_W-1:0]   pd_out_q;
    logic               pd_valid_q;
    logic               pd_err_q;

    logic               ack_fire;
    logic               tmo_fire;
    logic               pair_done;
    logic [SLOT_W-1:0]  slot1;
    logic [SLOT_W-1:0]  slot2;

    poly_slot_enc #(.NOTE_BASE(NOTE_BASE)) u_enc_sq1 (
        .note_on_i (sq1_no),
        .note_i    (sq1_n),
        .slot_o    (slot1)
    );

    poly_slot_enc #(.NOTE_BASE(NOTE_BASE)) u_enc_sq2 (
        .note_on_i (sq2_no),
        .note_i    (sq2_n),
        .slot_o    (slot2)
    );

    // An ack always wins over an expiring timer in the same cycle
    assign ack_fire  = (state_q == REQ) && rd_ack;
    assign tmo_fire  = (state_q == REQ) && !rd_ack && (timer_q == TMO_LAST);
    assign pair_done = ack_fire || tmo_fire;

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear, scan every pair, publish, back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start || pending_q) state_d = CLEAR;
            CLEAR:   state_d = REQ;
            REQ:     if (pair_done && (idx_q == LAST_IDX)) state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        rd_req = (state_q == REQ);
        busy   = (state_q != IDLE);
    end

    // Scan datapath next-state: accumulator, pair index, timer, error, pending
    always_comb begin
        acc_d     = acc_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        ferr_d    = ferr_q;
        pending_d = pending_q;

        // One request is remembered while busy; IDLE consumes it
        if (state_q == IDLE) begin
            pending_d = 1'b0;
        end else if (frame_start) begin
            pending_d = 1'b1;
        end

        case (state_q)
            CLEAR: begin
                acc_d   = '0;
                idx_d   = '0;
                ferr_d  = 1'b0;
                timer_d = '0;
            end
            REQ: begin
                if (ack_fire) begin
                    for (int p = 0; p < NUM_PAIRS; p++) begin
                        if (idx_q == 3'(p)) begin
                            acc_d[p*PAIR_W +: PAIR_W] = {slot2, slot1};
                        end
                    end
                end else if (tmo_fire) begin
                    ferr_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (pair_done) begin
                    timer_d = '0;
                    idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Scan datapath registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            ferr_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            ferr_q    <= ferr_d;
            pending_q <= pending_d;
        end
    end

    // Publish registers: display vector only ever changes as a whole frame
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pd_out_q   <= '0;
            pd_err_q   <= 1'b0;
            pd_valid_q <= 1'b0;
        end else begin
            pd_valid_q <= (state_q == PUBLISH);
            if (state_q == PUBLISH) begin
                pd_out_q <= acc_q;
                pd_err_q <= ferr_q;
            end
        end
    end

    assign rd_idx   = idx_q;
    assign pd_out   = pd_out_q;
    assign pd_valid = pd_valid_q;
    assign pd_err   = pd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_disp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_disp_seq
//  Description : Self-checking bench for poly_disp_seq: directed slot table,
//                timeout, request burst, mid-scan reset and random frames
//                with a voice-memory responder and a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_disp_seq;

    localparam int NP      = 8;
    localparam int TMO     = 255;
    localparam int BASE    = 36;
    localparam int NEVER   = 1000;

    logic         clk_sys = 1'b0;
    logic         reset_n;
    logic         frame_start;
    logic         rd_req;
    logic [2:0]   rd_idx;
    logic         rd_ack;
    logic         sq1_no, sq2_no;
    logic [6:0]   sq1_n, sq2_n;
    logic [255:0] pd_out;
    logic         pd_valid;
    logic         pd_err;
    logic         busy;

    poly_disp_seq #(.NUM_PAIRS(NP), .NOTE_BASE(BASE), .TIMEOUT(TMO)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .rd_req      (rd_req),
        .rd_idx      (rd_idx),
        .rd_ack      (rd_ack),
        .sq1_no      (sq1_no),
        .sq2_no      (sq2_no),
        .sq1_n       (sq1_n),
        .sq2_n       (sq2_n),
        .pd_out      (pd_out),
        .pd_valid    (pd_valid),
        .pd_err      (pd_err),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Voice memory seen by the sequencer, plus per-pair ack delay
    bit   on1 [NP];
    bit   on2 [NP];
    int   n1  [NP];
    int   n2  [NP];
    int   dly [NP];
    bit   ack_tie;

    int   n_pass  = 0;
    int   n_total = 0;
    int   stab_viol = 0;

    typedef struct {
        int          pair;
        bit          o1;
        int          m1;
        bit          o2;
        int          m2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Slot value straight from the encoding rule
    function automatic logic [15:0] enc(input bit on, input int n);
        int r;
        r = on ? 512 : 0;
        if (n >= BASE) r = r + (n - BASE);
        else           r = r + 1024;
        return 16'(r);
    endfunction

    function automatic logic [255:0] model_vec();
        logic [255:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) begin
            if (dly[p] < TMO) begin
                v[32*p +: 16]      = enc(on1[p], n1[p]);
                v[32*p + 16 +: 16] = enc(on2[p], n2[p]);
            end
        end
        return v;
    endfunction

    function automatic logic model_err();
        logic e;
        e = 1'b0;
        for (int p = 0; p < NP; p++) if (dly[p] >= TMO) e = 1'b1;
        return e;
    endfunction

    task automatic set_default();
        for (int p = 0; p < NP; p++) begin
            on1[p] = 0; on2[p] = 0; n1[p] = BASE; n2[p] = BASE; dly[p] = 0;
        end
    endtask

    task automatic rand_voices();
        for (int p = 0; p < NP; p++) begin
            on1[p] = 1'($urandom_range(0, 1));
            on2[p] = 1'($urandom_range(0, 1));
            n1[p]  = int'($urandom_range(0, 127));
            n2[p]  = int'($urandom_range(0, 127));
        end
    endtask

    // Responder: acks after dly[idx] waiting cycles; garbage data when not acking
    int         ack_cnt = 0;
    logic [2:0] cur_idx = 3'd0;
    always @(negedge clk_sys) begin
        if (!rd_req || rd_idx != cur_idx) begin
            cur_idx = rd_idx;
            ack_cnt = 0;
        end
        rd_ack = ack_tie || (rd_req && ack_cnt >= dly[rd_idx]);
        if (rd_ack) begin
            sq1_no = on1[rd_idx]; sq1_n = 7'(n1[rd_idx]);
            sq2_no = on2[rd_idx]; sq2_n = 7'(n2[rd_idx]);
        end else begin
            sq1_no = 1'($urandom); sq1_n = 7'($urandom);
            sq2_no = 1'($urandom); sq2_n = 7'($urandom);
        end
        if (rd_req) ack_cnt++;
    end

    // Display vector must hold between valid pulses
    logic [255:0] last_pd = '0;
    always @(negedge clk_sys) begin
        if (!reset_n || pd_valid) last_pd = pd_out;
        else if (pd_out !== last_pd) stab_viol++;
    end

    // Pulse frame_start (called at a negedge), then wait for pd_valid
    task automatic start_and_wait(input int max_e, output int lat, output bit got);
        frame_start = 1'b1;
        @(posedge clk_sys);
        #1 frame_start = 1'b0;
        got = 0;
        lat = -1;
        for (int e = 0; e < max_e; e++) begin
            @(negedge clk_sys);
            if (pd_valid) begin
                got = 1;
                lat = e;
                break;
            end
            @(posedge clk_sys);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        bit           got;
        logic [255:0] exp;
        int           nv, first, second;
        bit           found;

        tbl[0] = '{0, 1'b1, 60,  1'b0, 48,  16'h0218, 16'h000C};
        tbl[1] = '{3, 1'b0, 36,  1'b1, 30,  16'h0000, 16'h0600};
        tbl[2] = '{7, 1'b1, 127, 1'b1, 36,  16'h025B, 16'h0200};
        tbl[3] = '{2, 1'b0, 35,  1'b1, 37,  16'h0400, 16'h0201};
        tbl[4] = '{5, 1'b1, 0,   1'b0, 127, 16'h0600, 16'h005B};
        tbl[5] = '{1, 1'b1, 36,  1'b1, 35,  16'h0200, 16'h0600};

        reset_n     = 1'b0;
        frame_start = 1'b0;
        ack_tie     = 1'b1;
        set_default();
        repeat (3) @(negedge clk_sys);
        check("rst_pd_out",   pd_out,   '0);
        check("rst_pd_valid", pd_valid, 0);
        check("rst_pd_err",   pd_err,   0);
        check("rst_rd_req",   rd_req,   0);
        check("rst_busy",     busy,     0);
        check("rst_rd_idx",   rd_idx,   0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Directed slot table, rd_ack tied high
        for (int t = 0; t < 6; t++) begin
            set_default();
            on1[tbl[t].pair] = tbl[t].o1; n1[tbl[t].pair] = tbl[t].m1;
            on2[tbl[t].pair] = tbl[t].o2; n2[tbl[t].pair] = tbl[t].m2;
            exp = '0;
            exp[32*tbl[t].pair +: 16]      = tbl[t].e1;
            exp[32*tbl[t].pair + 16 +: 16] = tbl[t].e2;
            start_and_wait(50, lat, got);
            check("tbl_done", got, 1);
            if (t == 0) check("tbl_latency", lat, NP + 2);
            check("tbl_pd_out", pd_out, exp);
            check("tbl_pd_err", pd_err, 0);
            @(negedge clk_sys);
            check("tbl_valid_one_cycle", pd_valid, 0);
        end

        // Pair 5 never acknowledged
        ack_tie = 1'b0;
        set_default();
        rand_voices();
        dly[5] = NEVER;
        @(negedge clk_sys);
        start_and_wait(3000, lat, got);
        check("tmo_done",    got, 1);
        check("tmo_latency", lat, NP + 2 + TMO - 1);
        check("tmo_pd_out",  pd_out, model_vec());
        check("tmo_pd_err",  pd_err, 1);
        dly[5] = 0;
        @(negedge clk_sys);
        start_and_wait(100, lat, got);
        check("clean_done",   got, 1);
        check("clean_pd_out", pd_out, model_vec());
        check("clean_pd_err", pd_err, 0);

        // Three requests during one scan give exactly two frames
        ack_tie = 1'b1;
        set_default();
        on1[6] = 1; n1[6] = 50;
        @(negedge clk_sys);
        frame_start = 1'b1;
        @(posedge clk_sys);
        nv = 0; first = -1; second = -1;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk_sys);
            if (pd_valid) begin
                nv++;
                if (first < 0) first = e; else second = e;
                check("burst_pd_out", pd_out, model_vec());
            end
            frame_start = (e == 2 || e == 4);
            @(posedge clk_sys);
        end
        @(negedge clk_sys);
        frame_start = 1'b0;
        check("burst_count", nv, 2);
        check("burst_first", first, NP + 2);
        check("burst_gap",   second - first, NP + 3);

        // Random voices and ack delays 0..5, occasional dead pair
        ack_tie = 1'b0;
        for (int f = 0; f < 25; f++) begin
            rand_voices();
            for (int p = 0; p < NP; p++) dly[p] = int'($urandom_range(0, 5));
            if ($urandom_range(0, 5) == 0) dly[$urandom_range(0, NP-1)] = NEVER;
            @(negedge clk_sys);
            start_and_wait(3000, lat, got);
            check("rnd_done",   got, 1);
            check("rnd_pd_out", pd_out, model_vec());
            check("rnd_pd_err", pd_err, model_err());
        end

        // Reset while the scan is polling pair 4
        rand_voices();
        for (int p = 0; p < NP; p++) dly[p] = 3;
        @(negedge clk_sys);
        frame_start = 1'b1;
        @(negedge clk_sys);
        frame_start = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_sys);
            if (rd_req && rd_idx == 3'd4) begin
                found = 1;
                break;
            end
        end
        check("midrst_reached_idx4", found, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_rd_req",   rd_req,   0);
        check("midrst_busy",     busy,     0);
        check("midrst_pd_out",   pd_out,   '0);
        check("midrst_pd_valid", pd_valid, 0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("post_rst_idle", busy, 0);
        rand_voices();
        start_and_wait(200, lat, got);
        check("post_rst_done",   got, 1);
        check("post_rst_pd_out", pd_out, model_vec());
        check("post_rst_pd_err", pd_err, 0);

        repeat (3) @(negedge clk_sys);
        check("pd_out_stable", stab_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
